// File: rtl/alu_pkg.sv
// Shared definitions for the arbitrated ALU: op-codes, FSM encoding, widths.
package alu_pkg;

  localparam int DATA_W = 8;

  // ALU control codes as presented on reqN_op.
  typedef enum logic [2:0] {
    ADD  = 3'b000,
    SUB  = 3'b001,
    AND  = 3'b010,
    OR   = 3'b011,
    PASS = 3'b100,
    RAND = 3'b101,
    ROR  = 3'b110,
    SHL  = 3'b111
  } alu_op_e;

  // Arbiter FSM: accept in IDLE, compute in EXEC, hold the response in RESP.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/alu_arbiter_if.sv
// Bus bundle between two requesters, one response consumer and the arbiter.
//
// Handshake rule for every channel: a transfer happens on a rising clock edge
// where valid and ready are both high. A producer holds valid and its payload
// stable until that edge. Ready may depend combinationally on valid.
interface alu_arbiter_if;
  import alu_pkg::*;

  logic              req0_valid;
  logic              req0_ready;
  logic [2:0]        req0_op;
  logic [DATA_W-1:0] req0_a;
  logic [DATA_W-1:0] req0_b;

  logic              req1_valid;
  logic              req1_ready;
  logic [2:0]        req1_op;
  logic [DATA_W-1:0] req1_a;
  logic [DATA_W-1:0] req1_b;

  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_id;
  logic [DATA_W-1:0] rsp_y;
  logic              rsp_overflow;
  logic              rsp_zero;

  // Requesters and response consumer.
  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    output req1_valid, req1_op, req1_a, req1_b,
    output rsp_ready,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_id, rsp_y, rsp_overflow, rsp_zero
  );

  // Arbiter side.
  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    input  req1_valid, req1_op, req1_a, req1_b,
    input  rsp_ready,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_id, rsp_y, rsp_overflow, rsp_zero
  );
endinterface

// File: rtl/alu_arbiter_alu.sv
// Combinational 8-bit ALU; arithmetic is 9-bit unsigned so bit 8 is carry/borrow.
module alu
  import alu_pkg::*;
(
  input  alu_op_e           i_op,
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  output logic [DATA_W-1:0] o_y,
  output logic              o_overflow,
  output logic              o_zero
);

  logic [DATA_W:0] w_res;

  // Compute the 9-bit result; bit 8 is only ever set by add/sub.
  always_comb begin
    w_res = '0;
    case (i_op)
      ADD:  w_res = {1'b0, i_a} + {1'b0, i_b};
      SUB:  w_res = {1'b0, i_a} - {1'b0, i_b};
      AND:  w_res = {1'b0, i_a & i_b};
      OR:   w_res = {1'b0, i_a | i_b};
      PASS: w_res = {1'b0, i_b};
      RAND: w_res = {{DATA_W{1'b0}}, &i_b};
      ROR:  w_res = {{DATA_W{1'b0}}, |i_b};
      SHL:  w_res = (i_b >= 8'd8) ? '0 : {1'b0, i_a << i_b[2:0]};
      default: w_res = '0;
    endcase
  end

  assign o_y        = w_res[DATA_W-1:0];
  assign o_overflow = w_res[DATA_W];
  assign o_zero     = (w_res[DATA_W-1:0] == '0);

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of one ALU: accept, execute, hold response.
// One operation is in flight at a time; peak rate is one op per three clocks.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter bit RR_EN = 1'b1
)(
  input  logic          clk,
  input  logic          rst_n,
  alu_arbiter_if.slave  bus,
  output state_e        o_state
);

  state_e            r_state;
  state_e            w_state_nxt;

  // Id granted most recently; reset to 1 so requester 0 wins the first tie.
  logic              r_last;

  logic              r_id;
  alu_op_e           r_op;
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;

  logic              r_rsp_id;
  logic [DATA_W-1:0] r_rsp_y;
  logic              r_rsp_ov;
  logic              r_rsp_zero;

  logic              w_gnt0;
  logic              w_gnt1;
  logic              w_hs;
  logic [DATA_W-1:0] w_y;
  logic              w_ov;
  logic              w_zero;

  // Grant decision: only in IDLE, at most one requester, tie broken by pointer.
  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (r_state == IDLE) begin
      if (bus.req0_valid && bus.req1_valid) begin
        if (RR_EN && (r_last == 1'b0)) w_gnt1 = 1'b1;
        else                           w_gnt0 = 1'b1;
      end else if (bus.req0_valid) begin
        w_gnt0 = 1'b1;
      end else if (bus.req1_valid) begin
        w_gnt1 = 1'b1;
      end
    end
  end

  // A grant is only raised for a valid requester, so grant equals handshake.
  assign w_hs           = w_gnt0 | w_gnt1;
  assign bus.req0_ready = w_gnt0;
  assign bus.req1_ready = w_gnt1;

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_hs) w_state_nxt = EXEC;
      EXEC:    w_state_nxt = RESP;
      RESP:    if (bus.rsp_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Capture the accepted operation and move the round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last <= 1'b1;
      r_id   <= 1'b0;
      r_op   <= ADD;
      r_a    <= '0;
      r_b    <= '0;
    end else if (w_hs) begin
      r_last <= w_gnt1;
      r_id   <= w_gnt1;
      r_op   <= w_gnt1 ? alu_op_e'(bus.req1_op) : alu_op_e'(bus.req0_op);
      r_a    <= w_gnt1 ? bus.req1_a : bus.req0_a;
      r_b    <= w_gnt1 ? bus.req1_b : bus.req0_b;
    end
  end

  alu u_alu (
    .i_op       (r_op),
    .i_a        (r_a),
    .i_b        (r_b),
    .o_y        (w_y),
    .o_overflow (w_ov),
    .o_zero     (w_zero)
  );

  // Register the ALU result in EXEC; it stays put through RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_id   <= 1'b0;
      r_rsp_y    <= '0;
      r_rsp_ov   <= 1'b0;
      r_rsp_zero <= 1'b0;
    end else if (r_state == EXEC) begin
      r_rsp_id   <= r_id;
      r_rsp_y    <= w_y;
      r_rsp_ov   <= w_ov;
      r_rsp_zero <= w_zero;
    end
  end

  assign bus.rsp_valid    = (r_state == RESP);
  assign bus.rsp_id       = r_rsp_id;
  assign bus.rsp_y        = r_rsp_y;
  assign bus.rsp_overflow = r_rsp_ov;
  assign bus.rsp_zero     = r_rsp_zero;
  assign o_state          = r_state;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios then random traffic, checked
// against an arithmetic reference and a per-requester request queue model.
module tb_alu_arbiter;
  import alu_pkg::*;

  logic   clk;
  logic   rst_n;
  state_e rr_state;
  state_e fp_state;

  alu_arbiter_if rr_if ();
  alu_arbiter_if fp_if ();

  alu_arbiter #(.RR_EN(1'b1)) u_rr (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (rr_if),
    .o_state (rr_state)
  );

  alu_arbiter #(.RR_EN(1'b0)) u_fp (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (fp_if),
    .o_state (fp_state)
  );

  // Clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_assert = 0;
  int n_fail   = 0;

  // Pending operations per requester, {op, a, b}; head is presented on the bus.
  logic [18:0] q0[$];
  logic [18:0] q1[$];
  // Scoreboard: expected responses {id, overflow, y} in acceptance order.
  logic [9:0]  exp_q[$];
  int          last_id;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Reference ALU from plain integer arithmetic; returns {overflow, y}.
  function automatic logic [8:0] ref_alu(input logic [2:0] op, input logic [7:0] a,
                                         input logic [7:0] b);
    int ia, ib, r;
    logic [8:0] res;
    ia  = a;
    ib  = b;
    res = '0;
    case (op)
      3'd0: begin r = ia + ib; res = 9'(r); end
      3'd1: begin r = ia - ib; res[8] = (ia < ib); res[7:0] = 8'((r + 256) % 256); end
      3'd2: res = {1'b0, a & b};
      3'd3: res = {1'b0, a | b};
      3'd4: res = {1'b0, b};
      3'd5: res = (b == 8'hFF) ? 9'd1 : 9'd0;
      3'd6: res = (b != 8'h00) ? 9'd1 : 9'd0;
      default: res = (ib >= 8) ? 9'd0 : 9'((ia * (1 << ib)) % 256);
    endcase
    return res;
  endfunction

  function automatic logic [18:0] rand_op();
    logic [7:0] b;
    b = $urandom_range(0, 1) ? 8'($urandom_range(0, 10)) : 8'($urandom);
    return {3'($urandom_range(0, 7)), 8'($urandom), b};
  endfunction

  // Present the head of each queue on the round-robin DUT.
  task automatic drive();
    rr_if.req0_valid = (q0.size() != 0);
    {rr_if.req0_op, rr_if.req0_a, rr_if.req0_b} = (q0.size() != 0) ? q0[0] : 19'd0;
    rr_if.req1_valid = (q1.size() != 0);
    {rr_if.req1_op, rr_if.req1_a, rr_if.req1_b} = (q1.size() != 0) ? q1[0] : 19'd0;
  endtask

  // One full transaction from IDLE back to IDLE; response held `hold` extra cycles.
  task automatic serve(input int hold);
    int waited, exp_g, g;
    logic [18:0] hd;
    logic [9:0]  rx;
    drive();
    rr_if.rsp_ready = (hold == 0);
    #1;
    waited = 0;
    while (!(rr_if.req0_ready || rr_if.req1_ready) && waited < 8) begin
      @(posedge clk); #1;
      waited++;
    end
    check("grant_latency", waited, 0);
    if (waited >= 8) return;
    if (q0.size() != 0 && q1.size() != 0) exp_g = (last_id == 0) ? 1 : 0;
    else                                  exp_g = (q0.size() != 0) ? 0 : 1;
    check("ready_onehot", {rr_if.req0_ready, rr_if.req1_ready} == 2'b11, 0);
    g = rr_if.req1_ready ? 1 : 0;
    check("grant_id", g, exp_g);
    hd = (g == 1) ? q1.pop_front() : q0.pop_front();
    exp_q.push_back({g[0], ref_alu(hd[18:16], hd[15:8], hd[7:0])});
    last_id = g;
    // EXEC
    @(posedge clk); #1;
    drive();
    #1;
    check("exec_state", rr_state, EXEC);
    check("exec_rsp_valid", rr_if.rsp_valid, 0);
    check("exec_ready", {rr_if.req0_ready, rr_if.req1_ready}, 0);
    // RESP
    @(posedge clk); #1;
    rx = exp_q.pop_front();
    check("resp_state", rr_state, RESP);
    check("rsp_valid", rr_if.rsp_valid, 1);
    check("rsp_id", rr_if.rsp_id, rx[9]);
    check("rsp_y", rr_if.rsp_y, rx[7:0]);
    check("rsp_overflow", rr_if.rsp_overflow, rx[8]);
    check("rsp_zero", rr_if.rsp_zero, rx[7:0] == 8'h00);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      check("hold_valid", rr_if.rsp_valid, 1);
      check("hold_y", rr_if.rsp_y, rx[7:0]);
      check("hold_id", rr_if.rsp_id, rx[9]);
      check("hold_ready", {rr_if.req0_ready, rr_if.req1_ready}, 0);
    end
    rr_if.rsp_ready = 1'b1;
    @(posedge clk); #1;
    check("back_idle", rr_state, IDLE);
    check("idle_rsp_valid", rr_if.rsp_valid, 0);
    rr_if.rsp_ready = 1'b0;
  endtask

  // Stimulus and checks.
  initial begin
    int waited;
    rst_n = 1'b1;
    last_id = 1;
    drive();
    rr_if.rsp_ready  = 1'b0;
    fp_if.req0_valid = 1'b0; fp_if.req0_op = 3'd0; fp_if.req0_a = 8'h00; fp_if.req0_b = 8'h00;
    fp_if.req1_valid = 1'b0; fp_if.req1_op = 3'd0; fp_if.req1_a = 8'h00; fp_if.req1_b = 8'h00;
    fp_if.rsp_ready  = 1'b0;

    // Reset state.
    #2 rst_n = 1'b0;
    #1;
    check("rst_state", rr_state, IDLE);
    check("rst_rsp_valid", rr_if.rsp_valid, 0);
    check("rst_rsp_id", rr_if.rsp_id, 0);
    check("rst_rsp_y", rr_if.rsp_y, 0);
    check("rst_rsp_ov", rr_if.rsp_overflow, 0);
    check("rst_rsp_zero", rr_if.rsp_zero, 0);
    check("rst_ready", {rr_if.req0_ready, rr_if.req1_ready}, 0);
    check("rst_fp_state", fp_state, IDLE);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Add with carry out, grant in the first IDLE cycle after reset.
    q0.push_back({ADD, 8'hF0, 8'h20});
    serve(0);
    // Subtract with borrow, then equal operands.
    q1.push_back({SUB, 8'h03, 8'h05});
    serve(0);
    q1.push_back({SUB, 8'h05, 8'h05});
    serve(0);
    // Consumer stalls three cycles.
    q0.push_back({OR, 8'h5A, 8'h21});
    serve(3);
    // Oversized shift and reduce-AND, from requester 1.
    q1.push_back({SHL, 8'h01, 8'h09});
    serve(1);
    q1.push_back({RAND, 8'h00, 8'hFF});
    serve(0);

    // Both requesters continuously valid under round-robin.
    for (int k = 0; k < 4; k++) begin
      if (q0.size() == 0) q0.push_back({AND, 8'($urandom), 8'($urandom)});
      if (q1.size() == 0) q1.push_back({PASS, 8'($urandom), 8'($urandom)});
      serve(k % 2);
    end
    while (q0.size() != 0 || q1.size() != 0) serve(0);

    // Random traffic.
    for (int t = 0; t < 24; t++) begin
      if (q0.size() == 0 && $urandom_range(0, 1) == 1) q0.push_back(rand_op());
      if (q1.size() == 0 && $urandom_range(0, 1) == 1) q1.push_back(rand_op());
      if (q0.size() == 0 && q1.size() == 0) q0.push_back(rand_op());
      serve($urandom_range(0, 2));
    end
    while (q0.size() != 0 || q1.size() != 0) serve(0);

    // Reset during EXEC discards the operation. Leave a nonzero response first.
    q1.push_back({ROR, 8'h00, 8'h40});
    serve(0);
    q0.push_back({ADD, 8'h11, 8'h22});
    drive();
    rr_if.rsp_ready = 1'b1;
    #1;
    check("rstx_grant", rr_if.req0_ready, 1);
    @(posedge clk); #1;
    q0.delete(0);
    drive();
    check("rstx_exec", rr_state, EXEC);
    rst_n = 1'b0;
    #1;
    check("rstx_state", rr_state, IDLE);
    check("rstx_rsp_valid", rr_if.rsp_valid, 0);
    check("rstx_rsp_id", rr_if.rsp_id, 0);
    check("rstx_rsp_y", rr_if.rsp_y, 0);
    check("rstx_rsp_ov", rr_if.rsp_overflow, 0);
    check("rstx_rsp_zero", rr_if.rsp_zero, 0);
    last_id = 1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      check("rstx_no_rsp", rr_if.rsp_valid, 0);
    end
    rr_if.rsp_ready = 1'b0;
    // Tie right after reset goes to requester 0.
    q0.push_back({ADD, 8'h01, 8'h02});
    q1.push_back({ADD, 8'h03, 8'h04});
    serve(0);
    serve(0);

    // Fixed priority: requester 0 always wins while both are valid.
    fp_if.rsp_ready  = 1'b1;
    fp_if.req0_valid = 1'b1;
    fp_if.req1_valid = 1'b1;
    fp_if.req1_op    = ADD;
    fp_if.req1_a     = 8'h80;
    fp_if.req1_b     = 8'h00;
    for (int k = 0; k < 4; k++) begin
      fp_if.req0_op = ADD;
      fp_if.req0_a  = 8'(k);
      fp_if.req0_b  = 8'h01;
      #1;
      waited = 0;
      while (!(fp_if.req0_ready || fp_if.req1_ready) && waited < 8) begin
        @(posedge clk); #1;
        waited++;
      end
      check("fp_grant_latency", waited, 0);
      check("fp_grant0", fp_if.req0_ready, 1);
      check("fp_grant1", fp_if.req1_ready, 0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("fp_rsp_valid", fp_if.rsp_valid, 1);
      check("fp_rsp_id", fp_if.rsp_id, 0);
      check("fp_rsp_y", fp_if.rsp_y, k + 1);
      @(posedge clk); #1;
    end
    fp_if.req0_valid = 1'b0;
    fp_if.req1_valid = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  // Global time limit.
  initial begin
    #200000;
    n_fail++;
    $display("FAIL timeout: simulation did not complete, observed running expected finished");
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: RR_EN, default 1, 1 = round-robin arbitration, 0 = fixed priority to requester 0.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 req0_valid / req1_valid  input  1  requester N presents an operation.
REQ-005 req0_ready / req1_ready  output  1  requester N's operation accepted this cycle (valid & ready).
REQ-006 req0_op / req1_op  input  3  ALU control code: 000 add, 001 sub, 010 and, 011 or, 100 pass b, 101 reduce-AND b, 110 reduce-OR b, 111 a<<b.
REQ-007 req0_a, req0_b / req1_a, req1_b  input  8  operands.
REQ-008 rsp_valid  output  1  response available.
REQ-009 rsp_ready  input  1  response consumer accepts (valid & ready).
REQ-010 rsp_id  output  1  requester index owning the response.
REQ-011 rsp_y  output  8  ALU result.
REQ-012 rsp_overflow  output  1  bit 8 of the 9-bit add/sub result; 0 for all other ops.
REQ-013 rsp_zero  output  1  1 when rsp_y == 8'h00 (branch flag).

Function
REQ-014 The FSM SHALL have three states: IDLE, EXEC, RESP.
REQ-015 In IDLE, at most one of req0_ready/req1_ready SHALL be high, driven combinationally from the valids and the priority pointer; both SHALL be 0 in EXEC and RESP.
REQ-016 With only one valid, that requester SHALL be granted; with RR_EN=1 and both valid, the requester not granted last SHALL win; with RR_EN=0, requester 0 SHALL always win.
REQ-017 On a handshake, op/a/b and the grant id SHALL be latched, the pointer updated to the granted id, and the FSM SHALL move to EXEC.
REQ-018 In EXEC, the latched operands SHALL drive the ALU; y, overflow and zero SHALL be registered into the response registers, and the FSM SHALL move to RESP.
REQ-019 In RESP, rsp_valid SHALL be 1, and rsp_id/rsp_y/rsp_overflow/rsp_zero SHALL be held stable until rsp_ready; on rsp_valid & rsp_ready the FSM SHALL return to IDLE.
REQ-020 Latency SHALL be: accepting edge -> EXEC -> rsp_valid high in the cycle after the EXEC edge (2 clocks); peak throughput SHALL be one op per 3 clocks.
REQ-021 Arithmetic SHALL be 9-bit unsigned: add {ov,y}=a+b; sub {ov,y}=a-b (ov = borrow).
REQ-022 Op 101/110 SHALL produce a 1-bit result zero-extended to 8 bits.
REQ-023 For op 111, shift amounts >= 8 SHALL give 8'h00.
REQ-024 Requests arriving while not in IDLE SHALL remain pending: no ready, no loss, no reorder of the requester's own stream.
REQ-025 rsp_ready asserted outside RESP SHALL be ignored.

Reset
REQ-026 On rst_n low, the module SHALL immediately go to IDLE and clear rsp_valid, rsp_id, rsp_y, rsp_overflow and rsp_zero to 0, with the pointer set so requester 0 wins the next tie.
REQ-027 Reset during EXEC or RESP SHALL discard the in-flight operation; no response SHALL be issued for it.
REQ-028 The first grant SHALL be possible in the first IDLE cycle after rst_n deasserts.

Structure
REQ-029 The ALU op-code constants (ADD, SUB, AND, OR, PASS, RAND, ROR, SHL) and the FSM state encoding SHALL live in a shared package, alu_pkg.
REQ-030 The datapath SHALL be one instance of the existing combinational alu sub-module; all arbitration and registering SHALL sit in alu_arbiter.

Verification
REQ-031 req0 add a=F0 b=20, rsp_ready=1 -> rsp_valid 2 clocks after accept, rsp_id=0, y=10, overflow=1, zero=0.
REQ-032 req1 sub a=03 b=05 -> y=FE, overflow=1; then sub 05-05 -> y=00, overflow=0, zero=1.
REQ-033 Both valid continuously, RR_EN=1, 4 ops -> grant order 0,1,0,1; with RR_EN=0 -> 0,0,0,0.
REQ-034 rsp_ready held low for 3 cycles in RESP -> rsp_* stable, both req_ready=0; rsp_ready=1 -> IDLE the next cycle.
REQ-035 shl a=01 b=09 -> y=00, zero=1; reduce-AND b=FF -> y=01, overflow=0.
REQ-036 rst_n pulsed low during EXEC -> rsp_valid stays 0, outputs 0, and the next tie is granted to requester 0.
